// File: rtl/gpc_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpc_launch_ctrl
// Purpose  : SoC-side initiator for one GPC core's MMIO control-register
//            block. A launch pulse runs the full job handshake over a
//            single-outstanding request port: hold the core in PC reset,
//            program rd_ptr, release reset, enable the PC, raise start,
//            poll done (with a timeout), clear done and disable the PC.
// Ports    : clock, rst_n        - clock, asynchronous active-low reset
//            launch, rd_ptr_cfg  - job request and rd_ptr value to program
//            busy, job_done      - activity flag, completion pulse
//            timeout_err         - sticky timeout flag (cleared by launch)
//            req_*               - request port (valid/ready, wr, addr,
//                                  data, byte enables)
//            rsp_valid, rsp_data - read response port
// Revision : 1.0 - initial release
// ============================================================================
module gpc_launch_ctrl #(
  parameter logic [31:0] CSR_BASE = 32'h0040_0C00,
  parameter int          POLL_GAP = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        launch,
  input  logic [4:0]  rd_ptr_cfg,
  output logic        busy,
  output logic        job_done,
  output logic        timeout_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wr,
  output logic [31:0] req_addr,
  output logic [31:0] req_data,
  output logic [3:0]  req_byteen,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data
);

  // FSM encoding
  localparam logic [3:0] c_ST_IDLE     = 4'd0;
  localparam logic [3:0] c_ST_W_RST1   = 4'd1;
  localparam logic [3:0] c_ST_W_RDPTR  = 4'd2;
  localparam logic [3:0] c_ST_W_RST0   = 4'd3;
  localparam logic [3:0] c_ST_W_EN     = 4'd4;
  localparam logic [3:0] c_ST_W_START  = 4'd5;
  localparam logic [3:0] c_ST_GAP      = 4'd6;
  localparam logic [3:0] c_ST_RD_DONE  = 4'd7;
  localparam logic [3:0] c_ST_WAIT_RSP = 4'd8;
  localparam logic [3:0] c_ST_W_CLR    = 4'd9;
  localparam logic [3:0] c_ST_W_DIS    = 4'd10;

  // Control-register addresses
  localparam logic [31:0] c_ADDR_EN_PC  = CSR_BASE + 32'h00;
  localparam logic [31:0] c_ADDR_RST_PC = CSR_BASE + 32'h04;
  localparam logic [31:0] c_ADDR_RD_PTR = CSR_BASE + 32'h08;
  localparam logic [31:0] c_ADDR_START  = CSR_BASE + 32'h10;
  localparam logic [31:0] c_ADDR_DONE   = CSR_BASE + 32'h14;

  // Poll-gap counter runs 0 .. POLL_GAP-1 while in GAP
  localparam int                 c_GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);

  logic [3:0]         r_state;
  logic [3:0]         w_next_state;
  logic [4:0]         r_rd_ptr_q;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [15:0]        r_to_cnt;
  logic               r_via_clr;

  logic               r_busy;
  logic               r_job_done;
  logic               r_timeout_err;
  logic               r_req_valid;
  logic               r_req_wr;
  logic [31:0]        r_req_addr;
  logic [31:0]        r_req_data;
  logic [3:0]         r_req_byteen;

  logic               w_accept;
  logic               w_launch_go;
  logic               w_timed_out;
  logic               w_done_seen;
  logic               w_polling;
  logic               w_issue;
  logic               w_is_req;
  logic               w_pl_wr;
  logic [31:0]        w_pl_addr;
  logic [31:0]        w_pl_data;
  logic               w_unused_rsp;

  assign w_accept     = r_req_valid && req_ready;
  assign w_launch_go  = (r_state == c_ST_IDLE) && launch;
  assign w_timed_out  = (r_state == c_ST_GAP) && (r_to_cnt >= TIMEOUT);
  assign w_done_seen  = (r_state == c_ST_WAIT_RSP) && rsp_valid && rsp_data[0];
  assign w_polling    = (r_state == c_ST_GAP) || (r_state == c_ST_RD_DONE) ||
                        (r_state == c_ST_WAIT_RSP);
  // A request stays up until accepted; after acceptance it drops for one
  // cycle while the FSM enters the next state.
  assign w_issue      = w_is_req && !w_accept;
  assign w_unused_rsp = ^rsp_data[31:1];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:     if (launch)   w_next_state = c_ST_W_RST1;
      c_ST_W_RST1:   if (w_accept) w_next_state = c_ST_W_RDPTR;
      c_ST_W_RDPTR:  if (w_accept) w_next_state = c_ST_W_RST0;
      c_ST_W_RST0:   if (w_accept) w_next_state = c_ST_W_EN;
      c_ST_W_EN:     if (w_accept) w_next_state = c_ST_W_START;
      c_ST_W_START:  if (w_accept) w_next_state = c_ST_GAP;
      c_ST_GAP: begin
        // Timeout wins over the next poll; done is never cleared on this path
        if (w_timed_out) begin
          w_next_state = c_ST_W_DIS;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_next_state = c_ST_RD_DONE;
        end
      end
      c_ST_RD_DONE:  if (w_accept) w_next_state = c_ST_WAIT_RSP;
      c_ST_WAIT_RSP: begin
        // Always wait for the response so no read is left orphaned
        if (rsp_valid) begin
          w_next_state = rsp_data[0] ? c_ST_W_CLR : c_ST_GAP;
        end
      end
      c_ST_W_CLR:    if (w_accept) w_next_state = c_ST_W_DIS;
      c_ST_W_DIS:    if (w_accept) w_next_state = c_ST_IDLE;
      default:       w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (request payload of the current state)
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_req  = 1'b1;
    w_pl_wr   = 1'b1;
    w_pl_addr = 32'h0;
    w_pl_data = 32'h0;
    case (r_state)
      c_ST_W_RST1:  begin w_pl_addr = c_ADDR_RST_PC; w_pl_data = 32'h1; end
      c_ST_W_RDPTR: begin w_pl_addr = c_ADDR_RD_PTR; w_pl_data = {27'b0, r_rd_ptr_q}; end
      c_ST_W_RST0:  begin w_pl_addr = c_ADDR_RST_PC; w_pl_data = 32'h0; end
      c_ST_W_EN:    begin w_pl_addr = c_ADDR_EN_PC;  w_pl_data = 32'h1; end
      c_ST_W_START: begin w_pl_addr = c_ADDR_START;  w_pl_data = 32'h1; end
      c_ST_RD_DONE: begin w_pl_addr = c_ADDR_DONE;   w_pl_wr   = 1'b0;  end
      c_ST_W_CLR:   begin w_pl_addr = c_ADDR_DONE;   w_pl_data = 32'h0; end
      c_ST_W_DIS:   begin w_pl_addr = c_ADDR_EN_PC;  w_pl_data = 32'h0; end
      default: begin
        w_is_req = 1'b0;
        w_pl_wr  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, job bookkeeping and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr_q    <= 5'd0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= 16'd0;
      r_via_clr     <= 1'b0;
      r_busy        <= 1'b0;
      r_job_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_wr      <= 1'b0;
      r_req_addr    <= 32'h0;
      r_req_data    <= 32'h0;
      r_req_byteen  <= 4'h0;
    end else begin
      if (w_launch_go) begin
        r_rd_ptr_q <= rd_ptr_cfg;
      end

      if ((r_state == c_ST_GAP) && (r_gap_cnt != c_GAP_LAST)) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end

      // Measures start-to-done; saturates instead of wrapping
      if ((r_state == c_ST_W_START) && w_accept) begin
        r_to_cnt <= 16'd0;
      end else if (w_polling && (r_to_cnt != 16'hFFFF)) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      // Remembers that done was seen, so job_done only follows a clean finish
      if (w_launch_go) begin
        r_via_clr <= 1'b0;
      end else if (w_done_seen) begin
        r_via_clr <= 1'b1;
      end

      if (w_launch_go) begin
        r_timeout_err <= 1'b0;
      end else if (w_timed_out) begin
        r_timeout_err <= 1'b1;
      end

      r_busy       <= (w_next_state != c_ST_IDLE);
      r_job_done   <= (r_state == c_ST_W_DIS) && w_accept && r_via_clr;
      r_req_valid  <= w_issue;
      r_req_wr     <= w_issue ? w_pl_wr   : 1'b0;
      r_req_addr   <= w_issue ? w_pl_addr : 32'h0;
      r_req_data   <= w_issue ? w_pl_data : 32'h0;
      r_req_byteen <= w_issue ? 4'hF      : 4'h0;
    end
  end

  assign busy        = r_busy;
  assign job_done    = r_job_done;
  assign timeout_err = r_timeout_err;
  assign req_valid   = r_req_valid;
  assign req_wr      = r_req_wr;
  assign req_addr    = r_req_addr;
  assign req_data    = r_req_data;
  assign req_byteen  = r_req_byteen;

endmodule
`default_nettype wire

// File: tb/tb_gpc_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpc_launch_ctrl
// Purpose  : Self-checking bench for gpc_launch_ctrl. Stimulus pushes the
//            expected request stream into a scoreboard queue; a monitor pops
//            and compares every accepted request. A small target model
//            answers done reads from a queue of hand-chosen values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpc_launch_ctrl;

  localparam logic [31:0] BASE     = 32'h0040_0C00;
  localparam int          POLL_GAP = 4;
  localparam logic [15:0] TIMEOUT  = 16'd40;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clock;
  logic        rst_n;
  logic        launch;
  logic [4:0]  rd_ptr_cfg;
  logic        busy;
  logic        job_done;
  logic        timeout_err;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_byteen;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  logic        rm_valid;
  logic [31:0] rm_data;
  logic        spur_valid;
  logic [31:0] spur_data;

  assign rsp_valid = rm_valid | spur_valid;
  assign rsp_data  = spur_valid ? spur_data : rm_data;

  req_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          rsp_lat;
  int          rdy_mode;
  int          cyc;
  int          acc_cnt;
  int          jd_cnt;
  bit          rd_out;
  int          n_checks;
  int          n_pass;

  gpc_launch_ctrl #(
    .CSR_BASE (BASE),
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .launch      (launch),
    .rd_ptr_cfg  (rd_ptr_cfg),
    .busy        (busy),
    .job_done    (job_done),
    .timeout_err (timeout_err),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_byteen  (req_byteen),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endfunction

  // Ready driver: 0 = always ready, 1 = fixed 30% duty pattern, 2 = stalled
  initial begin
    req_ready = 1'b0;
    cyc       = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      case (rdy_mode)
        0:       req_ready = 1'b1;
        1:       req_ready = ((cyc % 10) == 0) || ((cyc % 10) == 3) || ((cyc % 10) == 7);
        default: req_ready = 1'b0;
      endcase
    end
  end

  // Target model: answers each accepted read rsp_lat cycles after acceptance
  initial begin
    logic [31:0] d;
    rm_valid = 1'b0;
    rm_data  = 32'h0;
    rd_out   = 1'b0;
    forever begin
      @(negedge clock);
      if (rst_n && req_valid && req_ready && !req_wr) begin
        d = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
        @(posedge clock);
        #1;
        rd_out = 1'b1;
        for (int k = 1; k < rsp_lat; k++) begin
          @(posedge clock);
          #1;
        end
        rd_out   = 1'b0;
        rm_valid = 1'b1;
        rm_data  = d;
        @(posedge clock);
        #1;
        rm_valid = 1'b0;
        rm_data  = 32'h0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          stall_prev;
    logic        p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    req_t        e;
    stall_prev = 1'b0;
    p_wr = 1'b0; p_addr = 32'h0; p_data = 32'h0;
    acc_cnt = 0;
    jd_cnt  = 0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check(req_valid && (req_wr == p_wr) && (req_addr == p_addr) && (req_data == p_data),
                "hold_stable", {req_addr, req_data}, {p_addr, p_data});
        end
        if (req_valid && req_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_req", {req_addr, req_data}, 64'h0);
          end else begin
            e = exp_q.pop_front();
            check((req_wr == e.wr) && (req_addr == e.addr) && (!e.wr || (req_data == e.data)) &&
                  (req_byteen == 4'hF),
                  e.wr ? "req_write" : "req_read", {req_addr, req_data}, {e.addr, e.data});
          end
        end
        if (rd_out) check(!req_valid, "no_req_while_wait", {63'h0, req_valid}, 64'h0);
        if (job_done) jd_cnt++;
        stall_prev = req_valid && !req_ready;
        p_wr   = req_wr;
        p_addr = req_addr;
        p_data = req_data;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    req_t r;
    r.wr = 1'b1; r.addr = addr; r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic push_job(input logic [4:0] ptr, input int nreads, input bit with_clr);
    req_t r;
    push_wr(BASE + 32'h04, 32'h1);
    push_wr(BASE + 32'h08, {27'b0, ptr});
    push_wr(BASE + 32'h04, 32'h0);
    push_wr(BASE + 32'h00, 32'h1);
    push_wr(BASE + 32'h10, 32'h1);
    for (int i = 0; i < nreads; i++) begin
      r.wr = 1'b0; r.addr = BASE + 32'h14; r.data = 32'h0;
      exp_q.push_back(r);
    end
    if (with_clr) push_wr(BASE + 32'h14, 32'h0);
    push_wr(BASE + 32'h00, 32'h0);
  endtask

  task automatic pulse_launch(input logic [4:0] ptr, input bit exp_busy_before);
    check(busy == exp_busy_before, "busy_before_launch", {63'h0, busy}, {63'h0, exp_busy_before});
    rd_ptr_cfg = ptr;
    launch     = 1'b1;
    step();
    launch     = 1'b0;
    check(busy == 1'b1, "busy_after_launch", {63'h0, busy}, 64'h1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || (exp_q.size() != 0)) && (k < 3000)) begin
      step();
      k++;
    end
    check(k < 3000, name, k, 3000);
    repeat (3) step();
  endtask

  task automatic wait_acc(input int target, input string name);
    int k;
    k = 0;
    while ((acc_cnt < target) && (k < 300)) begin
      step();
      k++;
    end
    check(acc_cnt >= target, name, acc_cnt, target);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int jd0;
    int lat;
    int k;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    launch     = 1'b0;
    rd_ptr_cfg = 5'd0;
    spur_valid = 1'b0;
    spur_data  = 32'h0;
    rdy_mode   = 0;
    rsp_lat    = 1;
    repeat (3) step();

    // Reset state
    check({busy, job_done, timeout_err} == 3'b000, "reset_flags",
          {61'h0, busy, job_done, timeout_err}, 64'h0);
    check({req_valid, req_wr, req_byteen} == 6'h0, "reset_req_ctl",
          {58'h0, req_valid, req_wr, req_byteen}, 64'h0);
    check({req_addr, req_data} == 64'h0, "reset_req_payload", {req_addr, req_data}, 64'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // Normal job: done reads 0, 0, 1
    push_job(5'd9, 3, 1'b1);
    rsp_q.push_back(32'h0); rsp_q.push_back(32'h0); rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    pulse_launch(5'd9, 1'b0);
    wait_idle("normal_idle");
    check((jd_cnt - jd0) == 1, "normal_job_done", jd_cnt - jd0, 1);
    check(timeout_err == 1'b0, "normal_timeout_err", {63'h0, timeout_err}, 64'h0);

    // Backpressure: 30% ready duty, same sequence
    rdy_mode = 1;
    push_job(5'd22, 3, 1'b1);
    rsp_q.push_back(32'h0); rsp_q.push_back(32'h0); rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    pulse_launch(5'd22, 1'b0);
    wait_idle("bp_idle");
    check((jd_cnt - jd0) == 1, "bp_job_done", jd_cnt - jd0, 1);
    rdy_mode = 0;
    repeat (2) step();

    // Minimum latency (ready high, 1-cycle response, done already set):
    // 5 writes x 2 + POLL_GAP + read 2 + response 1 + 2 writes x 2 + 1 = 18 + POLL_GAP.
    // A launch on the W_DIS acceptance edge (cycle 21) must be ignored.
    push_job(5'd3, 1, 1'b1);
    rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    lat = -1;
    rd_ptr_cfg = 5'd3;
    launch = 1'b1;
    step();
    for (int c = 1; c < 40; c++) begin
      launch = (c == 21);
      @(negedge clock);
      if (job_done && (lat < 0)) lat = c;
      step();
    end
    launch = 1'b0;
    check(lat == (18 + POLL_GAP), "min_latency", lat, 18 + POLL_GAP);
    check((jd_cnt - jd0) == 1, "lat_job_done", jd_cnt - jd0, 1);
    check(busy == 1'b0, "launch_at_wdis_ignored", {63'h0, busy}, 64'h0);
    check(exp_q.size() == 0, "lat_queue_empty", exp_q.size(), 0);

    // Timeout: done never set; 6 polls fit before the counter reaches 40
    push_job(5'd1, 6, 1'b0);
    jd0 = jd_cnt;
    pulse_launch(5'd1, 1'b0);
    wait_idle("timeout_idle");
    check(timeout_err == 1'b1, "timeout_err_set", {63'h0, timeout_err}, 64'h1);
    check((jd_cnt - jd0) == 0, "timeout_no_job_done", jd_cnt - jd0, 0);
    // Next launch clears the sticky flag
    push_job(5'd2, 1, 1'b1);
    rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    pulse_launch(5'd2, 1'b0);
    check(timeout_err == 1'b0, "timeout_err_cleared", {63'h0, timeout_err}, 64'h0);
    wait_idle("relaunch_idle");
    check((jd_cnt - jd0) == 1, "relaunch_job_done", jd_cnt - jd0, 1);

    // Launch while busy (in GAP) is ignored
    push_job(5'd7, 2, 1'b1);
    rsp_q.push_back(32'h0); rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    k = acc_cnt;
    pulse_launch(5'd7, 1'b0);
    wait_acc(k + 5, "busy_reach_gap");
    repeat (2) step();
    pulse_launch(5'd12, 1'b1);
    wait_idle("busy_idle");
    repeat (10) step();
    check((jd_cnt - jd0) == 1, "busy_single_job_done", jd_cnt - jd0, 1);

    // Async reset while W_EN is stalled
    push_wr(BASE + 32'h04, 32'h1);
    push_wr(BASE + 32'h08, 32'd4);
    push_wr(BASE + 32'h04, 32'h0);
    k = acc_cnt;
    pulse_launch(5'd4, 1'b0);
    wait_acc(k + 3, "rst_reach_wen");
    rdy_mode = 2;
    k = 0;
    while (!req_valid && (k < 20)) begin
      step();
      k++;
    end
    check(req_valid && (req_addr == BASE), "rst_wen_stalled", {req_addr, 31'h0, req_valid},
          {BASE, 32'h1});
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check({busy, job_done, timeout_err, req_valid, req_wr, req_byteen} == 9'h0, "async_rst_ctl",
          {55'h0, busy, job_done, timeout_err, req_valid, req_wr, req_byteen}, 64'h0);
    check({req_addr, req_data} == 64'h0, "async_rst_payload", {req_addr, req_data}, 64'h0);
    repeat (2) step();
    rst_n    = 1'b1;
    rdy_mode = 0;
    step();
    check(exp_q.size() == 0, "rst_queue_empty", exp_q.size(), 0);
    push_job(5'd4, 1, 1'b1);
    rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    pulse_launch(5'd4, 1'b0);
    wait_idle("post_rst_idle");
    check((jd_cnt - jd0) == 1, "post_rst_job_done", jd_cnt - jd0, 1);

    // Slow response (7 cycles) with stray rsp_valid pulses outside WAIT_RSP
    rsp_lat = 7;
    push_job(5'd11, 2, 1'b1);
    rsp_q.push_back(32'h0); rsp_q.push_back(32'h1);
    jd0 = jd_cnt;
    k = acc_cnt;
    pulse_launch(5'd11, 1'b0);
    repeat (2) step();
    spur_valid = 1'b1; spur_data = 32'h1;
    step();
    spur_valid = 1'b0; spur_data = 32'h0;
    wait_acc(k + 5, "slow_reach_gap");
    step();
    spur_valid = 1'b1; spur_data = 32'h1;
    step();
    spur_valid = 1'b0; spur_data = 32'h0;
    wait_idle("slow_idle");
    check((jd_cnt - jd0) == 1, "slow_job_done", jd_cnt - jd0, 1);
    rsp_lat = 1;

    check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
